mac_operand_feeder: RTL
=======================

// Module: mac_operand_feeder
// PURPOSE
//  Producer side of the pipelined multiply-accumulate (MAC) operand interface.
//  - Takes weights over a serial load port; holds them.
//  - Collects a serial valid/ready pixel stream into groups of NUM_INPUTS.
//  - Drives the MAC's packed pixel/weight buses and tracks MAC latency.
//  - Returns each MAC result with a one-cycle res_valid strobe.
//  - Sits between the pixel source and the MAC's IN_PIXELS/IN_WEIGHTS/OUT ports.
// PARAMETERS
//  NUM_INPUTS   4   pixels/weights per MAC operation (>=2)
//  PIXEL_W      10  unsigned pixel width
//  WEIGHT_W     19  weight width, 3 integer + 16 fraction bits (19'h10000 = 1.0)
//  OUT_W        26  MAC result width
//  MAC_LATENCY  3   cycles from MAC operand capture to valid MAC OUT (>=1)
// PORTS
//  clk          in   1                    clock, rising edge
//  rst          in   1                    synchronous reset, active-low
//  wt_restart   in   1                    pulse: discard weights and partial pixel group
//  wt_valid     in   1                    weight word valid
//  wt_data      in   WEIGHT_W             weight word
//  wt_ready     out  1                    feeder accepts weights (state WLOAD)
//  pix_valid    in   1                    pixel valid
//  pix_data     in   PIXEL_W              pixel
//  pix_ready    out  1                    feeder accepts pixels (state COLLECT)
//  mac_pixels   out  NUM_INPUTS*PIXEL_W   to MAC IN_PIXELS
//  mac_weights  out  NUM_INPUTS*WEIGHT_W  to MAC IN_WEIGHTS
//  mac_in_valid out  1                    one-cycle strobe, new operand set issued
//  mac_out      in   OUT_W                from MAC OUT
//  res_valid    out  1                    one-cycle strobe, res_data valid
//  res_data     out  OUT_W                captured MAC result
// BEHAVIOUR
//  Reset (rst==0 at a clk edge)
//  - Outputs: all zero; wt_ready=0; pix_ready=0.
//  - State, counters and the latency tag pipe are cleared.
//  - In-flight results are dropped; no res_valid follows.
//  - First edge with rst==1 enters WLOAD.
//  FSM states: WLOAD, COLLECT, ISSUE. All outputs are registered.
//  - WLOAD: wt_ready=1, pix_ready=0.
//    - Each wt_valid cycle stores wt_data and increments wcnt.
//    - When the NUM_INPUTS-th word is stored, wcnt clears and the next state is COLLECT.
//  - COLLECT: pix_ready=1.
//    - Handshake is pix_valid&&pix_ready; pcnt increments on each handshake.
//    - On the NUM_INPUTS-th handshake, the next state is ISSUE.
//  - ISSUE (one cycle): mac_in_valid=1, pix_ready=0, then back to COLLECT.
//    - Throughput: one group per NUM_INPUTS+1 cycles at best.
//  - wt_valid is ignored outside WLOAD.
//  Packing (matches the MAC concatenation order)
//  - The first-received item occupies the MSB slice (index NUM_INPUTS-1).
//  - The last-received item occupies the LSB slice (index 0).
//  - Example: pixels 1,2,3,4 give mac_pixels = {10'd1,10'd2,10'd3,10'd4}.
//  - mac_pixels/mac_weights update only on entry to ISSUE.
//    They stay stable until the next ISSUE, so the free-running MAC sees constant operands.
//  Latency tracking
//  - mac_in_valid feeds a MAC_LATENCY-deep tag shift register.
//  - If mac_in_valid=1 in cycle T, mac_out is sampled at the end of cycle T+MAC_LATENCY.
//  - res_valid=1 and res_data=that value appear in cycle T+MAC_LATENCY+1.
//  - res_data holds its value between strobes.
//  - There is no backpressure on results.
//  wt_restart (sampled each edge; has priority over the pixel handshake)
//  - Clears pcnt and wcnt; the next state is WLOAD.
//  - A pixel handshaking in the same cycle is discarded.
//  - In ISSUE, the issue completes (strobe already out) before moving to WLOAD.
//  - Tags already in flight still produce their res_valid.
//  - mac_weights keeps its old value until the next ISSUE.
// TESTING
//  1 rst=0 for 2 cycles, then 1 -> all outputs 0; next cycle wt_ready=1, pix_ready=0.
//  2 Load 4x 19'h10000, stream pixels 50,50,50,50, MAC model OUT=sum(p*w)
//    -> one mac_in_valid, mac_pixels={4{10'd50}}.
//    -> res_valid exactly MAC_LATENCY+1 cycles later, res_data = 200<<16.
//  3 Pixels 1,2,3,4 -> mac_pixels = {10'd1,10'd2,10'd3,10'd4};
//    weights load in the same order into mac_weights.
//  4 pix_valid toggling 1,0,1,1,0,1 -> only handshakes count;
//    ISSUE after the 4th; pix_ready=0 exactly in the ISSUE cycle.
//  5 2 pixels accepted, then wt_restart with pix_valid=1
//    -> partial group and coincident pixel dropped, WLOAD entered;
//    -> new weights + 4 pixels give one correct issue.
//  6 rst=0 one cycle after mac_in_valid -> no res_valid; FSM in WLOAD after release.

Source files
------------

// File: rtl/mac_operand_feeder_if.sv
// Bundle of the weight-load, pixel-stream, MAC operand and result signals around mac_operand_feeder.
// master is the feeder's view; slave is the pixel source / MAC side.
interface mac_operand_feeder_if #(
    parameter int NUM_INPUTS = 4,
    parameter int PIXEL_W    = 10,
    parameter int WEIGHT_W   = 19,
    parameter int OUT_W      = 26
);
    logic                           wt_restart;
    logic                           wt_valid;
    logic [WEIGHT_W-1:0]            wt_data;
    logic                           wt_ready;
    logic                           pix_valid;
    logic [PIXEL_W-1:0]             pix_data;
    logic                           pix_ready;
    logic [NUM_INPUTS*PIXEL_W-1:0]  mac_pixels;
    logic [NUM_INPUTS*WEIGHT_W-1:0] mac_weights;
    logic                           mac_in_valid;
    logic [OUT_W-1:0]               mac_out;
    logic                           res_valid;
    logic [OUT_W-1:0]               res_data;

    modport master (
        input  wt_restart, wt_valid, wt_data, pix_valid, pix_data, mac_out,
        output wt_ready, pix_ready, mac_pixels, mac_weights, mac_in_valid,
               res_valid, res_data
    );

    modport slave (
        output wt_restart, wt_valid, wt_data, pix_valid, pix_data, mac_out,
        input  wt_ready, pix_ready, mac_pixels, mac_weights, mac_in_valid,
               res_valid, res_data
    );
endinterface

// File: rtl/mac_operand_feeder.sv
// Producer side of the MAC operand interface: loads weights, groups pixels,
// issues packed operand sets and returns MAC results after a fixed latency.
//
// state   | meaning
// --------+-------------------------------------------------------------
// WLOAD   | accepting NUM_INPUTS weight words (wt_ready=1)
// COLLECT | accepting pixels until a full group is held (pix_ready=1)
// ISSUE   | one cycle: new operand set on the MAC buses, mac_in_valid=1
module mac_operand_feeder #(
    parameter int NUM_INPUTS  = 4,
    parameter int PIXEL_W     = 10,
    parameter int WEIGHT_W    = 19,
    parameter int OUT_W       = 26,
    parameter int MAC_LATENCY = 3
) (
    input logic                  clk,
    input logic                  rst,
    mac_operand_feeder_if.master bus
);
    localparam int PIX_BUS_W = NUM_INPUTS * PIXEL_W;
    localparam int WT_BUS_W  = NUM_INPUTS * WEIGHT_W;
    localparam int CNT_W     = $clog2(NUM_INPUTS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        S_WLOAD   = 2'd0,
        S_COLLECT = 2'd1,
        S_ISSUE   = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       wcnt;
    logic [CNT_W-1:0]       wcnt_nxt;
    logic [CNT_W-1:0]       pcnt;
    logic [CNT_W-1:0]       pcnt_nxt;
    logic                   wt_fire;
    logic                   pix_fire;
    logic                   wt_store;
    logic                   pix_store;
    logic                   group_done;

    logic                   wt_ready;
    logic                   pix_ready;
    logic                   mac_in_valid;
    logic [PIX_BUS_W-1:0]   mac_pixels;
    logic [WT_BUS_W-1:0]    mac_weights;
    logic                   res_valid;
    logic [OUT_W-1:0]       res_data;

    logic [WT_BUS_W-1:0]    wt_sr;
    logic [PIX_BUS_W-1:0]   pix_sr;
    logic [MAC_LATENCY-1:0] tag_pipe;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_WLOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // wt_restart outranks every handshake, including a completing pixel group.
    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        pcnt_nxt   = pcnt;
        wt_store   = 1'b0;
        pix_store  = 1'b0;
        group_done = 1'b0;
        wt_fire    = bus.wt_valid && wt_ready;
        pix_fire   = bus.pix_valid && pix_ready;

        if (bus.wt_restart) begin
            wcnt_nxt  = '0;
            pcnt_nxt  = '0;
            state_nxt = S_WLOAD;
        end else begin
            case (state)
                S_WLOAD: begin
                    if (wt_fire) begin
                        wt_store = 1'b1;
                        if (wcnt == LAST) begin
                            wcnt_nxt  = '0;
                            state_nxt = S_COLLECT;
                        end else begin
                            wcnt_nxt = wcnt + 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (pix_fire) begin
                        pix_store = 1'b1;
                        if (pcnt == LAST) begin
                            pcnt_nxt   = '0;
                            group_done = 1'b1;
                            state_nxt  = S_ISSUE;
                        end else begin
                            pcnt_nxt = pcnt + 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    state_nxt = S_COLLECT;
                end
                default: begin
                    state_nxt = S_WLOAD;
                end
            endcase
        end
    end

    // Readies and the issue strobe are decoded from the next state so they are
    // registered yet line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt         <= '0;
            pcnt         <= '0;
            wt_ready     <= 1'b0;
            pix_ready    <= 1'b0;
            mac_in_valid <= 1'b0;
        end else begin
            wcnt         <= wcnt_nxt;
            pcnt         <= pcnt_nxt;
            wt_ready     <= (state_nxt == S_WLOAD);
            pix_ready    <= (state_nxt == S_COLLECT);
            mac_in_valid <= group_done;
        end
    end

    // Items shift in at the LSB end, so the first received ends in the MSB slice.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wt_sr       <= '0;
            pix_sr      <= '0;
            mac_pixels  <= '0;
            mac_weights <= '0;
        end else begin
            if (wt_store) begin
                wt_sr <= {wt_sr[WT_BUS_W-WEIGHT_W-1:0], bus.wt_data};
            end
            if (pix_store) begin
                pix_sr <= {pix_sr[PIX_BUS_W-PIXEL_W-1:0], bus.pix_data};
            end
            if (group_done) begin
                mac_pixels  <= {pix_sr[PIX_BUS_W-PIXEL_W-1:0], bus.pix_data};
                mac_weights <= wt_sr;
            end
        end
    end

    // tag_pipe[MAC_LATENCY-1] is set in the last cycle the MAC needs, so
    // mac_out is captured at the end of that cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_pipe  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            tag_pipe[0] <= mac_in_valid;
            for (int i = 1; i < MAC_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            res_valid <= tag_pipe[MAC_LATENCY-1];
            if (tag_pipe[MAC_LATENCY-1]) begin
                res_data <= bus.mac_out;
            end
        end
    end

    assign bus.wt_ready     = wt_ready;
    assign bus.pix_ready    = pix_ready;
    assign bus.mac_pixels   = mac_pixels;
    assign bus.mac_weights  = mac_weights;
    assign bus.mac_in_valid = mac_in_valid;
    assign bus.res_valid    = res_valid;
    assign bus.res_data     = res_data;

endmodule
